// File: rtl/blowfish128_pkg.sv
// Shared constants, FSM state type and direction helper for the blowfish128 subkey scheduler.
package blowfish128_pkg;

  localparam int unsigned NUM_SKEYS = 20;
  localparam int unsigned SKEY_W    = 32;
  localparam int unsigned IDX_W     = 5;

  typedef enum logic [1:0] {
    StEmpty,
    StIdle,
    StStream
  } state_e;

  // Final P index of a schedule: P20 when encrypting, P1 when decrypting.
  function automatic logic [IDX_W-1:0] last_idx(input logic enc);
    return enc ? IDX_W'(NUM_SKEYS - 1) : '0;
  endfunction

endpackage

// File: rtl/blowfish128_skey_store.sv
// NUM_SKEYS x SKEY_W subkey register file: whole-array load, zeroize, combinational indexed read.
module blowfish128_skey_store
  import blowfish128_pkg::*;
(
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        load_i,
  input  logic                        zero_i,
  input  logic [NUM_SKEYS*SKEY_W-1:0] load_data_i,
  input  logic [IDX_W-1:0]            rd_idx_i,
  output logic [SKEY_W-1:0]           rd_data_o
);

  logic [SKEY_W-1:0] mem_q [NUM_SKEYS];

  always_ff @(posedge clk_i) begin
    if (rst_i || zero_i) begin
      for (int i = 0; i < int'(NUM_SKEYS); i++) mem_q[i] <= '0;
    end else if (load_i) begin
      for (int i = 0; i < int'(NUM_SKEYS); i++) mem_q[i] <= load_data_i[i*SKEY_W +: SKEY_W];
    end
  end

  // Explicit compare mux keeps out-of-range indices reading zero.
  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < int'(NUM_SKEYS); i++) begin
      if (rd_idx_i == IDX_W'(i)) rd_data_o = mem_q[i];
    end
  end

endmodule

// File: rtl/blowfish128_skey_sched.sv
// Captures the blowfish128 P-array and streams it to the round core, ascending or descending.
// Optional BLOWFISH128_SKEY_ZEROIZE_EN: key_flush also zeroes the store and sk_data.
module blowfish128_skey_sched
  import blowfish128_pkg::*;
(
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        skey_ready,
  input  logic [NUM_SKEYS*SKEY_W-1:0] P_in,
  input  logic                        key_flush,
  output logic                        keys_valid,
  input  logic                        start,
  input  logic                        Encrypt,
  output logic                        sk_valid,
  input  logic                        sk_ready,
  output logic [SKEY_W-1:0]           sk_data,
  output logic [IDX_W-1:0]            sk_idx,
  output logic                        sk_last,
  output logic                        sched_done
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              enc_q, enc_d;
  logic              keys_valid_q, keys_valid_d;
  logic              sk_valid_q, sk_valid_d;
  logic [SKEY_W-1:0] sk_data_q, sk_data_d;
  logic [IDX_W-1:0]  sk_idx_q, sk_idx_d;
  logic              sk_last_q, sk_last_d;
  logic              sched_done_q, sched_done_d;
  logic              load, zero;
  logic [SKEY_W-1:0] rd_data;

  blowfish128_skey_store u_store (
    .clk_i       (Clk),
    .rst_i       (Rst),
    .load_i      (load),
    .zero_i      (zero),
    .load_data_i (P_in),
    .rd_idx_i    (idx_d),
    .rd_data_o   (rd_data)
  );

  // The store is read at the next index so sk_data can be registered with its sk_idx.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    enc_d        = enc_q;
    keys_valid_d = keys_valid_q;
    sk_valid_d   = sk_valid_q;
    sk_data_d    = sk_data_q;
    sk_idx_d     = sk_idx_q;
    sk_last_d    = sk_last_q;
    sched_done_d = 1'b0;
    load         = 1'b0;
    zero         = 1'b0;

    if (key_flush) begin
      state_d      = StEmpty;
      keys_valid_d = 1'b0;
      sk_valid_d   = 1'b0;
      sk_last_d    = 1'b0;
`ifdef BLOWFISH128_SKEY_ZEROIZE_EN
      zero         = 1'b1;
      sk_data_d    = '0;
`endif
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (skey_ready) begin
            load         = 1'b1;
            keys_valid_d = 1'b1;
            state_d      = StIdle;
          end
        end
        StIdle: begin
          if (skey_ready) begin
            load = 1'b1;
          end else if (start) begin
            enc_d      = Encrypt;
            idx_d      = Encrypt ? '0 : IDX_W'(NUM_SKEYS - 1);
            state_d    = StStream;
            sk_valid_d = 1'b1;
            sk_data_d  = rd_data;
            sk_idx_d   = idx_d;
            sk_last_d  = (idx_d == last_idx(Encrypt));
          end
        end
        StStream: begin
          if (sk_valid_q && sk_ready) begin
            if (sk_last_q) begin
              sk_valid_d   = 1'b0;
              sk_last_d    = 1'b0;
              sched_done_d = 1'b1;
              state_d      = StIdle;
            end else begin
              idx_d     = enc_q ? idx_q + IDX_W'(1) : idx_q - IDX_W'(1);
              sk_data_d = rd_data;
              sk_idx_d  = idx_d;
              sk_last_d = (idx_d == last_idx(enc_q));
            end
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= StEmpty;
      idx_q        <= '0;
      enc_q        <= 1'b0;
      keys_valid_q <= 1'b0;
      sk_valid_q   <= 1'b0;
      sk_data_q    <= '0;
      sk_idx_q     <= '0;
      sk_last_q    <= 1'b0;
      sched_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      enc_q        <= enc_d;
      keys_valid_q <= keys_valid_d;
      sk_valid_q   <= sk_valid_d;
      sk_data_q    <= sk_data_d;
      sk_idx_q     <= sk_idx_d;
      sk_last_q    <= sk_last_d;
      sched_done_q <= sched_done_d;
    end
  end

  assign keys_valid = keys_valid_q;
  assign sk_valid   = sk_valid_q;
  assign sk_data    = sk_data_q;
  assign sk_idx     = sk_idx_q;
  assign sk_last    = sk_last_q;
  assign sched_done = sched_done_q;

endmodule

// File: doc/blowfish128_skey_sched.md
Name: blowfish128_skey_sched

Overview:
- Consumer end of the subkey generator interface: captures the 20-entry P-array when the generator raises skey_ready.
- Streams the stored subkeys one per handshake to the blowfish128 round datapath.
- Encrypt order is P1..P20; decrypt order is P20..P1.
- Sits between blowfish128_skeygen_v2 and the cipher round core; decouples key expansion from per-block processing.

Parameters:
- NUM_SKEYS, 20, number of P-array subkeys held.
- SKEY_W, 32, width of one subkey in bits.
- IDX_W, 5, index width; must satisfy 2^IDX_W >= NUM_SKEYS.

Ports:
- Clk  in  1  clock; all logic on rising edge.
- Rst  in  1  synchronous, active-high reset.
- skey_ready  in  1  generator's P-array valid (level).
- P_in  in  NUM_SKEYS*SKEY_W  flattened P-array; P1 = bits [31:0], P20 = bits [639:608].
- key_flush  in  1  discard stored keys.
- keys_valid  out  1  stored P-array is usable.
- start  in  1  begin streaming one schedule.
- Encrypt  in  1  direction, sampled only with start; 1 = ascending, 0 = descending.
- sk_valid  out  1  sk_data holds a subkey.
- sk_ready  in  1  round core accepts sk_data.
- sk_data  out  SKEY_W  current subkey.
- sk_idx  out  IDX_W  zero-based P index of sk_data (P1 -> 0).
- sk_last  out  1  sk_data is the final subkey of this schedule.
- sched_done  out  1  one-cycle pulse after the last handshake.

Behaviour:
- Reset: state EMPTY; key store zeroed; idx = 0. Outputs keys_valid, sk_valid, sk_data, sk_idx, sk_last and sched_done are all 0. Reset overrides every other input, including mid-stream.
- All outputs are registered.
- EMPTY state:
  - skey_ready = 1 -> capture P_in into the store; go to IDLE; keys_valid = 1 next cycle.
  - start is ignored.
- IDLE state:
  - start = 1 -> latch Encrypt; idx = 0 (encrypt) or NUM_SKEYS-1 (decrypt); go to STREAM.
  - Otherwise, skey_ready = 1 recaptures P_in every cycle it is high.
  - start and skey_ready in the same cycle: capture wins, start is ignored.
- STREAM state:
  - Latency: sk_valid = 1 the cycle after start is sampled; sk_data = store[idx]; sk_idx = idx; sk_last = 1 when idx is the final index for the latched direction.
  - Handshake = sk_valid & sk_ready. idx advances +1 (encrypt) or -1 (decrypt) on each handshake.
  - Without a handshake, sk_data, sk_idx and sk_last hold stable; sk_valid never drops without a handshake unless key_flush or Rst.
  - Back-to-back handshakes deliver one subkey per cycle: 20 subkeys in 20 cycles with sk_ready held high.
  - Handshake with sk_last = 1 -> sk_valid = 0 and sched_done = 1 next cycle; go to IDLE. sched_done deasserts the following cycle.
  - start and skey_ready are ignored while in STREAM. A level-held skey_ready is captured once IDLE is reached.
  - idx never wraps; it is bounded by the sk_last exit.
- key_flush, any state:
  - Next cycle: state EMPTY, keys_valid = 0, sk_valid = 0, sk_last = 0, no sched_done.
  - Priority over start, skey_ready and handshake in the same cycle.
- Encrypt changing mid-stream has no effect; direction is fixed per schedule.

Optional Feature:
- Macro: BLOWFISH128_SKEY_ZEROIZE_EN.
- Defined: key_flush also clears all store entries and sk_data to 0 in the same cycle as the EMPTY transition.
- Undefined: key_flush only clears keys_valid and state; store contents remain until overwritten, and sk_data holds its last value.

Decomposition:
- Package blowfish128_pkg:
  - constants NUM_SKEYS = 20, SKEY_W = 32, IDX_W = 5.
  - state enum {EMPTY, IDLE, STREAM}.
  - function last_idx(enc): returns 19 for encrypt, 0 for decrypt.
- Sub-module blowfish128_skey_store: NUM_SKEYS x SKEY_W register file with whole-array load, optional zeroize and indexed read.
- The FSM and index counter stay in the top module.

Test Plan:
- Load and encrypt stream:
  - Stimulus: Rst for 3 cycles; P_in with Pk = 32'hA5A5_0000 + k; skey_ready pulse; start with Encrypt = 1; sk_ready held 1.
  - Response: 20 consecutive beats of sk_data = A5A5_0001..A5A5_0014 with sk_idx 0..19; sk_last only on beat 20; sched_done 1 cycle later.
- Decrypt stream:
  - Stimulus: same keys, start with Encrypt = 0.
  - Response: first beat sk_data = A5A5_0014 at sk_idx 19; last beat sk_data = A5A5_0001 at sk_idx 0 with sk_last.
- Backpressure:
  - Stimulus: sk_ready toggles 1,0,0,1,...
  - Response: sk_data/sk_idx stable across stalled cycles; total 20 handshakes; order unchanged.
- Start before keys:
  - Stimulus: start from EMPTY.
  - Response: sk_valid stays 0, keys_valid stays 0; a later skey_ready then start streams normally.
- Flush mid-stream:
  - Stimulus: key_flush after beat 7.
  - Response: next cycle sk_valid = 0, keys_valid = 0, no sched_done. With BLOWFISH128_SKEY_ZEROIZE_EN, sk_data = 0.
- Reset mid-stream and capture timing:
  - Stimulus: Rst at beat 10; separately, skey_ready held during STREAM with new P_in.
  - Response: all outputs 0 after reset. The held skey_ready is not captured until IDLE; the next schedule carries the new keys.
